// File: rtl/periodic_multi_ch_writer_if.sv
`default_nettype none
// ============================================================================
//  Module   : periodic_multi_ch_writer_if
//  Brief    : Channel data inputs and bmem write port of the periodic writer.
//  Revision : 1.0 - initial release
// ============================================================================
interface periodic_multi_ch_writer_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32
);
    logic [NUM_CH*DATA_W-1:0] data_i;
    logic [NUM_CH-1:0]        data_valid;
    logic                     bmem_resp;
    logic                     bmem_wr_en;
    logic [DATA_W-1:0]        bmem_wr_data;
    logic [ADDR_W-1:0]        bmem_wr_addr;
    logic [NUM_CH-1:0]        overrun;
    logic                     busy;

    modport master (
        output data_i, data_valid, bmem_resp,
        input  bmem_wr_en, bmem_wr_data, bmem_wr_addr, overrun, busy
    );

    modport slave (
        input  data_i, data_valid, bmem_resp,
        output bmem_wr_en, bmem_wr_data, bmem_wr_addr, overrun, busy
    );
endinterface
`default_nettype wire

// File: rtl/periodic_multi_ch_writer.sv
`default_nettype none
// ============================================================================
//  Module   : periodic_multi_ch_writer
//  Brief    : Per-channel sample capture, periodic arming and round-robin
//             draining of channel samples into per-channel memory rings.
//  Revision : 1.0 - initial release
// ============================================================================
module periodic_multi_ch_writer #(
    parameter int                NUM_CH     = 4,
    parameter int                DATA_W     = 64,
    parameter int                ADDR_W     = 32,
    parameter int                PERIOD     = 200000,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h00050000,
    parameter logic [ADDR_W-1:0] CH_STRIDE  = 32'h00000100,
    parameter int                RING_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    periodic_multi_ch_writer_if.slave    bus
);

    localparam int                c_CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int                c_PTR_W = (RING_DEPTH > 1) ? $clog2(RING_DEPTH) : 1;
    localparam int                c_CNT_W = $clog2(PERIOD);
    localparam logic [ADDR_W-1:0] c_BYTES = ADDR_W'(DATA_W / 8);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [NUM_CH-1:0]   r_dv_q;
    logic [NUM_CH-1:0]   w_rise;
    logic [NUM_CH-1:0]   r_pending;
    logic [NUM_CH-1:0]   r_armed;
    logic [NUM_CH-1:0]   r_overrun;
    logic [DATA_W-1:0]   r_pend_data [NUM_CH];
    logic [c_PTR_W-1:0]  r_ptr       [NUM_CH];

    logic [c_CNT_W-1:0]  r_cnt;
    logic                w_tick;

    logic [NUM_CH-1:0]   w_rot;
    logic [NUM_CH-1:0]   w_gnt_oh;
    logic [c_CH_W-1:0]   w_gnt;
    logic                w_found;
    logic                w_grant;
    logic                w_done;
    logic [c_CH_W-1:0]   r_rr;
    logic [c_CH_W-1:0]   r_gnt;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   r_out_data;
    logic [ADDR_W-1:0]   r_out_addr;

    assign w_rise = bus.data_valid & ~r_dv_q;
    assign w_tick = (r_cnt == c_CNT_W'(PERIOD - 1));

    // Free-running period counter, independent of the write FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
        end
    end

    // Rotate armed bits so bit 0 is the round-robin pointer's channel.
    always_comb begin
        w_rot   = NUM_CH'({r_armed, r_armed} >> r_rr);
        w_found = 1'b0;
        w_gnt   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_gnt   = c_CH_W'((int'(r_rr) + k) % NUM_CH);
            end
        end
    end

    always_comb begin
        w_gnt_oh = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_gnt_oh[c] = w_grant && (w_gnt == c_CH_W'(c));
        end
    end

    assign w_addr = BASE_ADDR + ADDR_W'(w_gnt) * CH_STRIDE
                  + ADDR_W'(r_ptr[w_gnt]) * c_BYTES;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                if (bus.bmem_resp) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A rise on the channel being granted refills pending without counting
    // as an overrun; arming uses pending as it stood before this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dv_q    <= '0;
            r_pending <= '0;
            r_armed   <= '0;
            r_overrun <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_pend_data[c] <= '0;
            end
        end else begin
            r_dv_q    <= bus.data_valid;
            r_pending <= (r_pending & ~w_gnt_oh) | w_rise;
            r_overrun <= r_overrun | (w_rise & r_pending & ~w_gnt_oh);
            r_armed   <= (r_armed | ({NUM_CH{w_tick}} & r_pending)) & ~w_gnt_oh;
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_rise[c]) begin
                    r_pend_data[c] <= bus.data_i[c*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr       <= '0;
            r_gnt      <= '0;
            r_out_data <= '0;
            r_out_addr <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_ptr[c] <= '0;
            end
        end else begin
            if (w_grant) begin
                r_gnt      <= w_gnt;
                r_out_data <= r_pend_data[w_gnt];
                r_out_addr <= w_addr;
                r_rr       <= (w_gnt == c_CH_W'(NUM_CH - 1)) ? '0 : w_gnt + 1'b1;
            end
            if (w_done) begin
                r_ptr[r_gnt] <= (RING_DEPTH == 1) ? '0 : r_ptr[r_gnt] + 1'b1;
            end
        end
    end

    assign bus.bmem_wr_en   = (r_state == S_WRITE);
    assign bus.busy         = (r_state == S_WRITE);
    assign bus.bmem_wr_data = (r_state == S_WRITE) ? r_out_data : '0;
    assign bus.bmem_wr_addr = (r_state == S_WRITE) ? r_out_addr : '0;
    assign bus.overrun      = r_overrun;

endmodule
`default_nettype wire

// File: doc/periodic_multi_ch_writer.md
Name: periodic_multi_ch_writer

Overview:
- Multi-channel successor to the single-channel periodic memory writer.
- Snapshots CDC-delivered data per channel on each data_valid rising edge.
- Every PERIOD cycles, arms all channels holding unsent data, then drains them round-robin onto the bmem write port.
- Each channel writes into its own ring of RING_DEPTH slots in memory, with a proper hold-until-resp handshake and per-channel sticky overrun flags.

Parameters:
- NUM_CH, 4, number of independent input channels (1..8).
- DATA_W, 64, data width per channel and bmem write width; multiple of 8.
- ADDR_W, 32, bmem address width.
- PERIOD, 200000, tick period in clk cycles (>=2).
- BASE_ADDR, 32'h00050000, address of channel 0, slot 0.
- CH_STRIDE, 32'h00000100, address offset between channel regions; must be >= RING_DEPTH*DATA_W/8.
- RING_DEPTH, 8, slots per channel ring; power of two.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- data_i  in  NUM_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W]
- data_valid  in  NUM_CH  per-channel level from CDC; rising edge = new sample
- bmem_resp  in  1  write accepted; 1-cycle pulse
- bmem_wr_en  out  1  write request, held until resp
- bmem_wr_data  out  DATA_W  write data
- bmem_wr_addr  out  ADDR_W  write address
- overrun  out  NUM_CH  sticky: channel sample overwritten before it was sent
- busy  out  1  high in state WRITE

Behaviour:
- Reset values:
  - Outputs: bmem_wr_en=0, bmem_wr_data=0, bmem_wr_addr=0, overrun=0, busy=0.
  - Internal: tick counter=0, all pending/armed bits=0, ring ptrs=0, rr pointer=0, state=IDLE.
- Edge detect:
  - dv_q[c] registers data_valid[c]; rise[c] = data_valid[c] & ~dv_q[c].
- Capture:
  - On rise[c]: pend_data[c] <= data_i slice; pending[c] <= 1.
  - If pending[c] was already 1 and c is not being granted that cycle: overwrite the data and set overrun[c]. overrun clears only on rst.
- Tick:
  - Counter runs 0..PERIOD-1 and wraps.
  - tick is high in the cycle counter==PERIOD-1; the counter runs continuously, independent of state.
  - On tick: armed <= armed | pending (using registered pending, before any same-cycle capture).
  - Samples captured after a tick wait for the next tick.
- FSM IDLE:
  - If armed != 0: grant channel g, the first armed channel at or after rr_ptr, wrapping modulo NUM_CH.
  - Load out_data <= pend_data[g] and out_addr <= BASE_ADDR + g*CH_STRIDE + ptr[g]*(DATA_W/8).
  - Clear pending[g] and armed[g]; rr_ptr <= g+1 (mod NUM_CH); go to WRITE.
  - A rise[g] in the grant cycle wins: pending[g] stays 1 with the new data, and overrun is not set.
- FSM WRITE:
  - bmem_wr_en=1; data and addr stay stable until bmem_resp.
  - On bmem_resp: ptr[g] <= ptr[g]+1, wrapping at RING_DEPTH; go to IDLE. bmem_wr_en drops the next cycle.
  - Minimum spacing between writes is 2 cycles (one IDLE cycle).
- Outputs outside WRITE: wr_data and wr_addr are driven 0 (never X).
- bmem_resp outside WRITE is ignored.
- Latency: a channel armed at tick cycle T, with no contention, asserts bmem_wr_en at T+2.
- Simultaneous events:
  - A tick during WRITE arms other channels normally; the in-flight channel is re-armed only if it captured new data before the tick.
  - Tick and grant in the same cycle: the granted channel's armed bit stays cleared, because its pending was consumed.
- Ring ptr arithmetic: ptr is $clog2(RING_DEPTH) bits; natural wrap.
- Address arithmetic: computed in ADDR_W bits, truncating.
- Reset mid-WRITE: bmem_wr_en=0 the next cycle. The in-flight write is abandoned and not retried; all state returns to reset values.

Test Plan:
- Single channel, basic write. Config NUM_CH=2, PERIOD=16. Rise on ch0 with data 64'hA5 at cycle 3 → at tick (cycle 15) wr_en rises at 17, addr=32'h00050000, data=64'hA5. Hold resp low 5 cycles: outputs stable. Resp → wr_en low next cycle.
- Round-robin and ring advance. ch0 and ch1 both pending before tick → writes ch0 at 32'h00050000, then ch1 at 32'h00050100. Repeat next period → ch0 slot 1 at 32'h00050008.
- Ring wrap. Nine periods of writes on ch0 with RING_DEPTH=8 → ninth write returns to 32'h00050000.
- Overrun. Two ch1 rises (data 1, then 2) within one period → single write of data 2, overrun=2'b10 and it stays set. A rise landing exactly on the grant cycle does not set overrun.
- Late sample. ch0 rise at cycle 15 (tick cycle) → no write this period; write in the next period at cycle 33.
- Reset mid-WRITE. rst asserted while wr_en=1 and resp withheld → wr_en=0, wr_data=0, overrun=0 next cycle. After release, no write occurs until new rise plus tick, and the ring restarts at slot 0.
